clahe_frame_sched: RTL and testbench

//  Frame-level scheduler for the CLAHE 16-tile ping-pong histogram/LUT RAM bank.
//  - Gates histogram statistics per frame.
//  - At frame end, sequences CDF/LUT generation for all tiles, one handshake per tile.
//  - Clears the next statistics bank once mapping has drained, then toggles ping_pong_flag.
//  - Sits between video timing, histogram, CDF engine, mapping pipeline and the RAM bank.

---
 rtl/clahe_pkg.sv | 17 +
 rtl/clahe_sched_watchdog.sv | 20 ++
 rtl/clahe_frame_sched.sv | 101 ++++++++++
 tb/tb_clahe_frame_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/clahe_pkg.sv
// clahe_pkg: shared scheduler state encoding and tile/frame geometry for the CLAHE frame scheduler
package clahe_pkg;
  localparam int TILE_NUM = 16;
  localparam int TILE_IDX_W = 4;
  localparam int FRAME_CNT_W = 16;
  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_CDF_REQ,
    S_CDF_WAIT,
    S_MAP_WAIT,
    S_CLR_REQ,
    S_CLR_ACK,
    S_CLR_WAIT,
    S_SWAP
  } sched_state_t;
endpackage

// File: rtl/clahe_sched_watchdog.sv
// clahe_sched_watchdog: per-wait-state cycle counter, cleared on load, flags expiry after LIMIT enabled cycles
module clahe_sched_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  assign expire = en && (cnt == CW'(LIMIT - 1));
  // count enabled cycles since the last load, holding once expired
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/clahe_frame_sched.sv
// clahe_frame_sched: frame-level CDF/clear/swap sequencer for the CLAHE ping-pong bank; optional watchdog via CLAHE_SCHED_TIMEOUT_EN
module clahe_frame_sched
  import clahe_pkg::*;
#(
  parameter int TILE_NUM_P    = TILE_NUM,
  parameter int TILE_IDX_W_P  = TILE_IDX_W,
  parameter int FRAME_CNT_W_P = FRAME_CNT_W
`ifdef CLAHE_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     frame_done,
  input  logic                     map_idle,
  input  logic                     cdf_done,
  input  logic                     clear_done,
  output logic                     stat_en,
  output logic                     cdf_start,
  output logic [TILE_IDX_W_P-1:0]  cdf_tile_idx,
  output logic                     clear_start,
  output logic                     ping_pong_flag,
  output logic                     lut_valid,
  output logic                     sched_busy,
  output logic [FRAME_CNT_W_P-1:0] frame_cnt,
  output logic                     err_overrun,
  output logic                     err_timeout
);
  sched_state_t state_q, state_d;
  logic wd_exp;
  logic go, accept, adv, last;
  assign go = (state_q == S_IDLE) && stat_en && frame_done;
  assign accept = frame_start && ((state_q == S_SWAP) || ((state_q == S_IDLE) && !go));
  assign adv = (state_q == S_CDF_WAIT) && (cdf_done || wd_exp);
  assign last = cdf_tile_idx == TILE_IDX_W_P'(TILE_NUM_P - 1);
  assign cdf_start = state_q == S_CDF_REQ;
  assign clear_start = state_q == S_CLR_REQ;
  assign sched_busy = state_q != S_IDLE;
  // state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else state_q <= state_d;
  end
  // next-state logic; a watchdog expiry stands in for the awaited event
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:     state_d = clear_done ? S_IDLE : S_INIT;
      S_IDLE:     state_d = go ? S_CDF_REQ : S_IDLE;
      S_CDF_REQ:  state_d = S_CDF_WAIT;
      S_CDF_WAIT: state_d = adv ? (last ? S_MAP_WAIT : S_CDF_REQ) : S_CDF_WAIT;
      S_MAP_WAIT: state_d = (map_idle || wd_exp) ? S_CLR_REQ : S_MAP_WAIT;
      S_CLR_REQ:  state_d = S_CLR_ACK;
      S_CLR_ACK:  state_d = (!clear_done || wd_exp) ? S_CLR_WAIT : S_CLR_ACK;
      S_CLR_WAIT: state_d = (clear_done || wd_exp) ? S_SWAP : S_CLR_WAIT;
      S_SWAP:     state_d = S_IDLE;
      default:    state_d = S_INIT;
    endcase
  end
  // frame gating, tile index, bank swap bookkeeping and overrun flag
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_en        <= 1'b0;
      cdf_tile_idx   <= '0;
      ping_pong_flag <= 1'b0;
      lut_valid      <= 1'b0;
      frame_cnt      <= '0;
      err_overrun    <= 1'b0;
    end else begin
      stat_en      <= go ? 1'b0 : (accept ? 1'b1 : stat_en);
      err_overrun  <= err_overrun | (frame_start & !accept);
      cdf_tile_idx <= go ? '0 : ((adv && !last) ? cdf_tile_idx + 1'b1 : cdf_tile_idx);
      if (state_q == S_SWAP) begin
        ping_pong_flag <= ~ping_pong_flag;
        lut_valid      <= 1'b1;
        frame_cnt      <= frame_cnt + 1'b1;
      end
    end
  end
`ifdef CLAHE_SCHED_TIMEOUT_EN
  logic wd_en;
  assign wd_en = state_q inside {S_CDF_WAIT, S_MAP_WAIT, S_CLR_ACK, S_CLR_WAIT};
  clahe_sched_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .load   (state_d != state_q),
    .en     (wd_en),
    .expire (wd_exp)
  );
  // sticky timeout flag
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) err_timeout <= 1'b0;
    else if (wd_exp) err_timeout <= 1'b1;
  end
`else
  assign wd_exp = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_clahe_frame_sched.sv
// tb_clahe_frame_sched: directed/randomized bench acting as video timing, CDF engine, mapper and RAM bank
module tb_clahe_frame_sched;
  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0, frame_done = 1'b0, map_idle = 1'b1, cdf_done = 1'b0, clear_done = 1'b0;
  logic stat_en, cdf_start, clear_start, ping_pong_flag, lut_valid, sched_busy, err_overrun, err_timeout;
  logic [3:0] cdf_tile_idx;
  logic [15:0] frame_cnt;
  int n_chk = 0, n_fail = 0;
  int exp_cnt = 0;
  bit exp_ovr = 0;

  clahe_frame_sched dut (
    .pclk(pclk), .rst_n(rst_n), .frame_start(frame_start), .frame_done(frame_done),
    .map_idle(map_idle), .cdf_done(cdf_done), .clear_done(clear_done), .stat_en(stat_en),
    .cdf_start(cdf_start), .cdf_tile_idx(cdf_tile_idx), .clear_start(clear_start),
    .ping_pong_flag(ping_pong_flag), .lut_valid(lut_valid), .sched_busy(sched_busy),
    .frame_cnt(frame_cnt), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input int which, output bit ok);
    ok = 0;
    for (int k = 0; k < 512; k++) begin
      if ((which == 0) ? cdf_start : clear_start) begin
        ok = 1;
        break;
      end
      @(negedge pclk);
    end
  endtask

  task automatic check_reset_outs();
    chk("rst_busy", sched_busy, 1);
    chk("rst_stat_en", stat_en, 0);
    chk("rst_cdf_start", cdf_start, 0);
    chk("rst_tile_idx", cdf_tile_idx, 0);
    chk("rst_clear_start", clear_start, 0);
    chk("rst_flag", ping_pong_flag, 0);
    chk("rst_lut_valid", lut_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_overrun", err_overrun, 0);
    chk("rst_timeout", err_timeout, 0);
  endtask

  task automatic init(input int hold);
    rst_n = 1'b0;
    {frame_start, frame_done, cdf_done, clear_done} = '0;
    map_idle = 1'b1;
    exp_cnt = 0;
    exp_ovr = 0;
    repeat (3) @(negedge pclk);
    check_reset_outs();
    rst_n = 1'b1;
    repeat (hold) @(negedge pclk);
    chk("init_busy_held", sched_busy, 1);
    clear_done = 1'b1;
    @(negedge pclk);
    chk("init_idle", sched_busy, 0);
    chk("init_flag", ping_pong_flag, 0);
    chk("init_lut_valid", lut_valid, 0);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge pclk);
    frame_start = 1'b0;
    chk("stat_en_on", stat_en, 1);
    repeat ($urandom_range(2, 6)) @(negedge pclk);
    frame_done = 1'b1;
    @(negedge pclk);
    frame_done = 1'b0;
    chk("first_cdf_latency", cdf_start, 1);
    chk("stat_en_off", stat_en, 0);
  endtask

  task automatic run_tiles(input int map_delay, input int ovr_tile, input bit swap_start, input int rst_tile);
    bit ok, bad;
    map_idle = (map_delay == 0);
    for (int t = 0; t < 16; t++) begin
      wait_sig(0, ok);
      chk("cdf_start_seen", ok, 1);
      chk("tile_idx", cdf_tile_idx, t);
      chk("no_clr_with_cdf", clear_start, 0);
      if (t == rst_tile) begin
        rst_n = 1'b0;
        #1;
        check_reset_outs();
        init(20);
        return;
      end
      cdf_done = (t == 0);
      @(negedge pclk);
      cdf_done = 1'b0;
      if (t == ovr_tile) begin
        frame_start = 1'b1;
        @(negedge pclk);
        frame_start = 1'b0;
        exp_ovr = 1;
        chk("overrun_flag", err_overrun, 1);
        chk("overrun_stat_en", stat_en, 0);
      end
      repeat ($urandom_range(0, 3)) @(negedge pclk);
      cdf_done = 1'b1;
      @(negedge pclk);
      cdf_done = 1'b0;
    end
    bad = 0;
    for (int k = 0; k < map_delay; k++) begin
      bad |= clear_start | (ping_pong_flag != exp_cnt[0]);
      @(negedge pclk);
    end
    chk("map_wait_hold", bad, 0);
    map_idle = 1'b1;
    wait_sig(1, ok);
    chk("clear_start_seen", ok, 1);
    chk("no_cdf_with_clr", cdf_start, 0);
    chk("flag_before_swap", ping_pong_flag, exp_cnt[0]);
    @(negedge pclk);
    clear_done = 1'b0;
    repeat ($urandom_range(8, 256)) @(negedge pclk);
    chk("flag_during_clear", ping_pong_flag, exp_cnt[0]);
    clear_done = 1'b1;
    @(negedge pclk);
    frame_start = swap_start;
    @(negedge pclk);
    frame_start = 1'b0;
    exp_cnt++;
    chk("swap_flag", ping_pong_flag, exp_cnt[0]);
    chk("swap_lut_valid", lut_valid, 1);
    chk("swap_frame_cnt", frame_cnt, 16'(exp_cnt));
    chk("swap_idle", sched_busy, 0);
    chk("swap_stat_en", stat_en, swap_start);
    chk("swap_overrun", err_overrun, exp_ovr);
  endtask

  task automatic run_frame(input int map_delay, input int ovr_tile, input bit swap_start, input int rst_tile);
    start_frame();
    run_tiles(map_delay, ovr_tile, swap_start, rst_tile);
  endtask

  initial begin
    init(512);
    run_frame(0, -1, 0, -1);
    run_frame(100, -1, 1, -1);
    frame_start = 1'b1;
    frame_done = 1'b1;
    @(negedge pclk);
    {frame_start, frame_done} = 2'b00;
    exp_ovr = 1;
    chk("sim_done_wins", cdf_start, 1);
    chk("sim_stat_en", stat_en, 0);
    chk("sim_overrun", err_overrun, 1);
    run_tiles(0, -1, 0, -1);
    init(40);
    run_frame($urandom_range(0, 30), 5, 0, -1);
    frame_done = 1'b1;
    @(negedge pclk);
    frame_done = 1'b0;
    @(negedge pclk);
    chk("skipped_done_ignored", sched_busy, 0);
    chk("skipped_frame_cnt", frame_cnt, 16'(exp_cnt));
    for (int f = 0; f < 3; f++) run_frame($urandom_range(0, 30), -1, 1'($urandom_range(0, 1)), -1);
    run_frame(0, -1, 0, 9);
    run_frame($urandom_range(0, 10), -1, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
